// File: rtl/float_triple_collector.sv
// Groups an FLEN-bit float stream into PAD_VALUE-padded triples, ping-pongs two of them, and issues each to the sorter.
// Latency: 2 cycles from the triple-closing accept to the sort_valid_in pulse. Backpressure: in_ready drops while both slots are full.
module float_triple_collector #(
  parameter int              FLEN      = 64,
  parameter logic [FLEN-1:0] PAD_VALUE = 64'h7FF0_0000_0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FLEN-1:0]     in_data,
  input  logic                in_last,
  output logic                sort_valid_in,
  output logic [3*FLEN-1:0]   sort_unsorted,
  output logic [1:0]          sort_pad,
  input  logic                sort_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [FLEN-1:0] slot_dat [2][3];
  logic [1:0]      slot_pad [2];
  logic [1:0]      slot_full, slot_full_nxt;
  logic [1:0]      full_count;
  logic            wr_sel, rd_sel;
  logic [1:0]      idx;
  logic            accept, complete, load;

  assign full_count    = {1'b0, slot_full[0]} + {1'b0, slot_full[1]};
  assign in_ready      = (full_count < 2'd2);
  assign accept        = in_valid & in_ready;
  assign complete      = accept & (in_last | (idx == 2'd2));
  assign sort_valid_in = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if ((full_count != 2'd0) && !sort_busy) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (!sort_busy) begin
          if (full_count != 2'd0) begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slots fill and drain in strict alternation, so wr_sel never points at a slot being freed.
  always_comb begin
    slot_full_nxt = slot_full;
    if (load)     slot_full_nxt[rd_sel] = 1'b0;
    if (complete) slot_full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 3; k++) slot_dat[s][k] <= '0;
        slot_pad[s] <= 2'd0;
      end
      slot_full     <= 2'b00;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      idx           <= 2'd0;
      sort_unsorted <= '0;
      sort_pad      <= 2'd0;
    end else begin
      slot_full <= slot_full_nxt;
      if (accept) begin
        slot_dat[wr_sel][idx] <= in_data;
        if (complete) begin
          for (int k = 1; k < 3; k++)
            if (2'(k) > idx) slot_dat[wr_sel][2'(k)] <= PAD_VALUE;
          slot_pad[wr_sel] <= 2'd2 - idx;
          wr_sel           <= ~wr_sel;
          idx              <= 2'd0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
      if (load) begin
        sort_unsorted <= {slot_dat[rd_sel][0], slot_dat[rd_sel][1], slot_dat[rd_sel][2]};
        sort_pad      <= slot_pad[rd_sel];
        rd_sel        <= ~rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_float_triple_collector.sv
// Directed bench for float_triple_collector with a 3-cycle sorter busy model.
module tb_float_triple_collector;

  localparam logic [63:0] PAD = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F3  = 64'h4008_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [63:0]  in_data = '0;
  logic         ext_busy = 1'b0;
  logic         in_ready;
  logic         sort_valid_in;
  logic [191:0] sort_unsorted;
  logic [1:0]   sort_pad;
  logic         sort_busy;

  float_triple_collector #(.FLEN(64), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .sort_valid_in(sort_valid_in),
    .sort_unsorted(sort_unsorted), .sort_pad(sort_pad), .sort_busy(sort_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sorter model: busy for 3 cycles after each accepted valid_in.
  int scnt = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst)               scnt <= 0;
    else if (sort_valid_in) scnt <= 3;
    else if (scnt != 0)     scnt <= scnt - 1;
  end
  assign sort_busy = ext_busy | (scnt != 0);

  typedef struct {
    int           cyc;
    logic [191:0] dat;
    logic [1:0]   pad;
  } strobe_t;
  strobe_t q[$];

  always @(negedge clk) begin
    if (rst && sort_valid_in) q.push_back('{cyc, sort_unsorted, sort_pad});
  end

  typedef struct {
    string           name;
    logic [2:0][63:0] w;
    int              n;
    logic            last_on_final;
    logic [191:0]    exp_dat;
    logic [1:0]      exp_pad;
  } vec_t;
  vec_t tbl[5];

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", w);
    end else begin
      step();
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_strobe(input int n, input int budget);
    int w = 0;
    while (q.size() < n && w < budget) begin
      step();
      w++;
    end
    if (q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: got %0d strobes, required %0d", q.size(), n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sw[9];

    tbl[0] = '{"s1_3_1_2",      {F2, F1, F3},                    3, 1'b0, {F3, F1, F2},   2'd0};
    tbl[1] = '{"s2_single",     {64'h0, 64'h0, F1},              1, 1'b1, {F1, PAD, PAD}, 2'd2};
    tbl[2] = '{"s2_pair",       {64'h0, F3, F2},                 2, 1'b1, {F2, F3, PAD},  2'd1};
    tbl[3] = '{"s6_last_third", {F2, F1, F3},                    3, 1'b1, {F3, F1, F2},   2'd0};
    tbl[4] = '{"neg_mix",       {64'h8000_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'hBFF8_0000_0000_0000},
               3, 1'b0,
               {64'hBFF8_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'h8000_0000_0000_0000}, 2'd0};

    // Reset state
    repeat (3) step();
    chk("rst_valid", 192'(sort_valid_in), 192'(0));
    chk("rst_unsorted", sort_unsorted, 192'(0));
    chk("rst_pad", 192'(sort_pad), 192'(0));
    rst = 1'b1;
    step();
    chk("rst_in_ready", 192'(in_ready), 192'(1));

    // Table-driven triples, sorter idle
    foreach (tbl[v]) begin
      q.delete();
      for (int i = 0; i < tbl[v].n; i++)
        send(tbl[v].w[i], tbl[v].last_on_final && (i == tbl[v].n - 1));
      wait_strobe(1, 20);
      if (q.size() > 0) begin
        chk({tbl[v].name, "_data"}, q[0].dat, tbl[v].exp_dat);
        chk({tbl[v].name, "_pad"}, 192'(q[0].pad), 192'(tbl[v].exp_pad));
        chk({tbl[v].name, "_latency"}, 192'(q[0].cyc - acc_cyc + 1), 192'(2));
      end
      repeat (8) step();
      chk({tbl[v].name, "_one_strobe"}, 192'(q.size()), 192'(1));
    end

    // Continuous 9-word stream
    repeat (5) step();
    q.delete();
    for (int i = 0; i < 9; i++) sw[i] = 64'h4010_0000_0000_0000 + 64'(i);
    for (int i = 0; i < 9; i++) send(sw[i], 1'b0);
    wait_strobe(3, 40);
    repeat (10) step();
    chk("stream_count", 192'(q.size()), 192'(3));
    if (q.size() >= 3) begin
      for (int s = 0; s < 3; s++) begin
        chk("stream_data", q[s].dat, {sw[3*s], sw[3*s+1], sw[3*s+2]});
        chk("stream_pad", 192'(q[s].pad), 192'(0));
      end
      chk("stream_gap01", 192'(q[1].cyc - q[0].cyc), 192'(5));
      chk("stream_gap12", 192'(q[2].cyc - q[1].cyc), 192'(5));
    end

    // External busy holds issue; two buffered triples give backpressure
    q.delete();
    ext_busy = 1'b1;
    send(F1, 1'b0); send(F2, 1'b0); send(F3, 1'b0);
    repeat (8) step();
    chk("busy_no_strobe", 192'(q.size()), 192'(0));
    chk("busy_one_slot_ready", 192'(in_ready), 192'(1));
    send(F3, 1'b0); send(F2, 1'b1);
    chk("busy_full_not_ready", 192'(in_ready), 192'(0));
    repeat (4) step();
    chk("busy_still_none", 192'(q.size()), 192'(0));
    begin
      int r;
      r = cyc;
      ext_busy = 1'b0;
      wait_strobe(1, 10);
      if (q.size() > 0) begin
        chk("busy_release_delay", 192'(q[0].cyc - r + 1), 192'(2));
        chk("busy_first_data", q[0].dat, {F1, F2, F3});
      end
      chk("busy_ready_after_free", 192'(in_ready), 192'(1));
      wait_strobe(2, 20);
      if (q.size() > 1) begin
        chk("busy_second_data", q[1].dat, {F3, F2, PAD});
        chk("busy_second_pad", 192'(q[1].pad), 192'(1));
        chk("busy_second_gap", 192'(q[1].cyc - q[0].cyc), 192'(5));
      end
    end

    // Reset mid-triple (idx = 1)
    repeat (8) step();
    send(64'hDEAD_0000_0000_0001, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 192'(sort_valid_in), 192'(0));
    chk("rst_mid_unsorted", sort_unsorted, 192'(0));
    chk("rst_mid_pad", 192'(sort_pad), 192'(0));
    repeat (2) step();
    rst = 1'b1;
    step();
    q.delete();
    send(F2, 1'b0); send(F3, 1'b0); send(F1, 1'b0);
    wait_strobe(1, 20);
    if (q.size() > 0) begin
      chk("rst_fresh_data", q[0].dat, {F2, F3, F1});
      chk("rst_fresh_pad", 192'(q[0].pad), 192'(0));
    end

    // Reset mid-WAIT with a second triple buffered
    repeat (8) step();
    q.delete();
    send(F1, 1'b0); send(F1, 1'b0); send(F1, 1'b0);
    send(F2, 1'b0); send(F2, 1'b0); send(F2, 1'b1);
    wait_strobe(1, 20);
    step();
    rst = 1'b0;
    #1;
    chk("rst_wait_valid", 192'(sort_valid_in), 192'(0));
    chk("rst_wait_unsorted", sort_unsorted, 192'(0));
    repeat (2) step();
    rst = 1'b1;
    repeat (15) step();
    chk("rst_wait_discard", 192'(q.size()), 192'(1));
    chk("rst_wait_ready", 192'(in_ready), 192'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_triple_collector.md
Name: float_triple_collector

Overview:
- Upstream feeder for the three-float FSM sorter.
- Accepts a stream of FLEN-bit floats over a valid/ready handshake and groups every three words, or fewer when `in_last` is seen, into a triple.
- Buffers up to two complete triples (ping-pong) and issues each one to the sorter with a single-cycle `valid_in` pulse, respecting the sorter's `busy`.
- Short triples are padded with PAD_VALUE so the sorter always sees three operands.

Parameters:
- FLEN, 64, float word width; matches the codebase-wide float width.
- PAD_VALUE, 64'h7FF0_0000_0000_0000, FLEN-bit filler for missing words (+inf in binary64).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream word valid
- in_ready  out  1  collector can accept a word
- in_data  in  FLEN  float word
- in_last  in  1  qualified by in_valid; closes the current triple after this word
- sort_valid_in  out  1  one-cycle issue strobe to sorter `valid_in`
- sort_unsorted  out  3*FLEN  triple [0:2] to sorter `unsorted`; element 0 = first word received
- sort_pad  out  2  number of padded words (0..2) in the triple on sort_unsorted
- sort_busy  in  1  sorter `busy`

Behaviour:
- Reset (rst low, async) state:
  - FSM = IDLE; both slots empty; fill index = 0; wr_sel = rd_sel = 0.
  - sort_valid_in = 0; sort_unsorted = 0; sort_pad = 0.
  - in_ready = 1 once rst is released.
- Reset asserted mid-operation discards partial and complete triples; no strobe is emitted.
- Storage:
  - Two slots, each 3×FLEN data plus a 2-bit pad count.
  - full_count 0..2, wr_sel, rd_sel, fill index idx 0..2.
- `in_ready` = (full_count < 2). It depends only on registered state; there is no combinational path from sort_busy or in_valid.
- Accept = in_valid & in_ready. Word is written to slot[wr_sel][idx].
- Triple completion occurs when idx==2, or when in_last is set on the accepted word:
  - Elements idx+1..2 are written with PAD_VALUE; pad count = 2-idx.
  - Slot is marked full; wr_sel toggles; idx returns to 0.
  - Otherwise idx increments.
- in_last with idx==2 gives pad count 0, identical to a normal triple.
- Dispatch FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when full_count>0 & !sort_busy. On that edge sort_unsorted/sort_pad are loaded from slot[rd_sel], rd_sel toggles and the slot is freed.
  - ISSUE: sort_valid_in = 1 for exactly this one cycle; sort_unsorted is stable. Always -> WAIT.
  - WAIT: stays while sort_busy = 1. When sort_busy = 0: -> ISSUE if full_count>0 (loading as above), else -> IDLE.
- sort_unsorted/sort_pad hold their last issued value until the next load.
- Same-cycle completion of one slot and freeing of another leaves full_count unchanged. Writing into a slot being freed in the same cycle is impossible: wr_sel != rd_sel whenever both are active.
- Latency: the word completing a triple accepted in cycle t → sort_valid_in high in cycle t+2, given the sorter is idle.
- Throughput against the 3-cycle sorter: one issue every 5 cycles (ISSUE, 3 busy cycles, WAIT exit cycle).
- Backpressure: with both slots full, in_ready = 0 until the next IDLE/WAIT→ISSUE transition frees a slot (edge at end of that cycle).
- sort_busy high in IDLE blocks issue indefinitely; no timeout.

Test Plan:
1. Feed 64'h4008…0 (3.0), 64'h3FF0…0 (1.0), 64'h4000…0 (2.0) back-to-back, sorter idle:
   - sort_valid_in high exactly one cycle, 2 cycles after the third accept.
   - sort_unsorted = {3.0, 1.0, 2.0}; sort_pad = 0.
   - Sorter output is {1.0, 2.0, 3.0}.
2. Feed 1.0 with in_last = 1:
   - sort_unsorted = {1.0, PAD, PAD}; sort_pad = 2.
   - Then feed 2.0, 3.0 (last on 3.0) → {2.0, 3.0, PAD}, sort_pad = 1.
3. Stream 9 words continuously with in_valid held high:
   - in_ready drops to 0 once two slots are full.
   - Exactly 3 strobes occur, 5 cycles apart, in arrival order.
   - No word is lost or duplicated.
4. Hold sort_busy = 1 externally with one triple buffered:
   - No sort_valid_in while busy is high.
   - Strobe 2 cycles after sort_busy falls (IDLE→ISSUE transition, then ISSUE cycle).
5. Assert rst low mid-triple (idx = 1) and mid-WAIT:
   - Outputs clear immediately.
   - After release, a fresh 3-word triple is issued with no remnants of the old data.
6. Single word with in_last at idx = 2 (third word):
   - sort_pad = 0; behaves identically to scenario 1.
